// File: rtl/mic_gate_pkg.sv
// Shared types and register-map constants for the multi-channel mic gate.
// The top level and the per-channel block both import this package.
package mic_gate_pkg;

   typedef enum logic [1:0] {
      CLOSED = 2'd0,
      OPEN   = 2'd1,
      HOLD   = 2'd2
   } gate_state_t;

   localparam logic [5:0] ADDR_STATUS = 6'd0;
   localparam logic [5:0] ADDR_FLAGS  = 6'd1;
   localparam logic [5:0] ADDR_IRQ_EN = 6'd2;
   localparam logic [5:0] ADDR_CTRL   = 6'd3;
   localparam int         CH_BASE     = 8;
   localparam int         CH_STRIDE   = 4;

   localparam logic [1:0] OFF_LEVEL  = 2'd0;
   localparam logic [1:0] OFF_THR_HI = 2'd1;
   localparam logic [1:0] OFF_THR_LO = 2'd2;
   localparam logic [1:0] OFF_HOLD   = 2'd3;

   // Word address of register 'off' in channel k's window.
   function automatic logic [5:0] ch_addr(input int k, input logic [1:0] off);
      return 6'(CH_BASE + CH_STRIDE * k + int'(off));
   endfunction

endpackage

// File: rtl/mic_gate_channel.sv
// One mic channel: LEVEL/THR_HI/THR_LO/HOLD registers plus the hysteresis
// and hold-time gate FSM. Exposes its FSM state directly.
module mic_gate_channel
   import mic_gate_pkg::*;
#(
   parameter int LVL_W      = 16,
   parameter int HOLD_W     = 8,
   parameter int THR_HI_RST = 1200,
   parameter int THR_LO_RST = 1000,
   parameter int HOLD_RST   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_i,
   input  logic              level_ready_i,
   input  logic [LVL_W-1:0]  level_i,
   input  logic              thr_hi_we_i,
   input  logic              thr_lo_we_i,
   input  logic              hold_we_i,
   input  logic [15:0]       wr_data_i,
   output logic [LVL_W-1:0]  level_o,
   output logic [LVL_W-1:0]  thr_hi_o,
   output logic [LVL_W-1:0]  thr_lo_o,
   output logic [HOLD_W-1:0] hold_o,
   output logic              open_evt_o,
   output gate_state_t       state_o
);

   gate_state_t       state_q, state_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic [LVL_W-1:0]  level_q, thr_hi_q, thr_lo_q;
   logic [HOLD_W-1:0] hold_q;
   logic              hi_hit, lo_miss;

   // Decisions use the incoming level, not the stored LEVEL register.
   assign hi_hit  = (level_i >= thr_hi_q);
   assign lo_miss = (level_i < thr_lo_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      open_evt_o = 1'b0;
      if (!enable_i) begin
         state_d = CLOSED;
         cnt_d   = '0;
      end else if (level_ready_i) begin
         case (state_q)
            CLOSED: begin
               if (hi_hit) begin
                  state_d    = OPEN;
                  open_evt_o = 1'b1;
               end
            end
            OPEN: begin
               if (lo_miss) begin
                  if (hold_q != '0) begin
                     state_d = HOLD;
                     cnt_d   = hold_q;
                  end else begin
                     state_d = CLOSED;
                  end
               end
            end
            HOLD: begin
               if (hi_hit) begin
                  state_d = OPEN;
                  cnt_d   = '0;
               end else if (cnt_q == HOLD_W'(1)) begin
                  state_d = CLOSED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - HOLD_W'(1);
               end
            end
            default: begin
               state_d = CLOSED;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= CLOSED;
         cnt_q    <= '0;
         level_q  <= '0;
         thr_hi_q <= LVL_W'(THR_HI_RST);
         thr_lo_q <= LVL_W'(THR_LO_RST);
         hold_q   <= HOLD_W'(HOLD_RST);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (level_ready_i) level_q  <= level_i;
         if (thr_hi_we_i)   thr_hi_q <= wr_data_i[LVL_W-1:0];
         if (thr_lo_we_i)   thr_lo_q <= wr_data_i[LVL_W-1:0];
         if (hold_we_i)     hold_q   <= wr_data_i[HOLD_W-1:0];
      end
   end

   assign level_o  = level_q;
   assign thr_hi_o = thr_hi_q;
   assign thr_lo_o = thr_lo_q;
   assign hold_o   = hold_q;
   assign state_o  = state_q;

endmodule

// File: rtl/mic_gate_multi_mmio.sv
// Multi-channel mic gate with a 16-bit MMIO register file, sticky W1C event
// flags and a maskable level interrupt.
module mic_gate_multi_mmio
   import mic_gate_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int LVL_W      = 16,
   parameter int HOLD_W     = 8,
   parameter int THR_HI_RST = 1200,
   parameter int THR_LO_RST = 1000,
   parameter int HOLD_RST   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [5:0]            address,
   input  logic [15:0]           wr_data,
   output logic [15:0]           rd_data,
   input  logic [N_CH*LVL_W-1:0] level_in,
   input  logic [N_CH-1:0]       level_ready_in,
   output logic [N_CH-1:0]       gate_open,
   output logic                  irq
);

   logic              wr_stb, rd_stb;
   logic              enable_q;
   logic [N_CH-1:0]   new_lvl_q, new_lvl_d, open_evt_q, open_evt_d;
   logic [N_CH-1:0]   irq_en_new_q, irq_en_open_q;
   logic [N_CH-1:0]   clr_new, clr_open, open_evt_set;
   logic [LVL_W-1:0]  level_ch  [N_CH];
   logic [LVL_W-1:0]  thr_hi_ch [N_CH];
   logic [LVL_W-1:0]  thr_lo_ch [N_CH];
   logic [HOLD_W-1:0] hold_ch   [N_CH];
   gate_state_t       state_ch  [N_CH];

   assign wr_stb = cs && wr_en;
   assign rd_stb = cs && rd_en;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      mic_gate_channel #(
         .LVL_W      (LVL_W),
         .HOLD_W     (HOLD_W),
         .THR_HI_RST (THR_HI_RST),
         .THR_LO_RST (THR_LO_RST),
         .HOLD_RST   (HOLD_RST)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .enable_i      (enable_q),
         .level_ready_i (level_ready_in[k]),
         .level_i       (level_in[k*LVL_W +: LVL_W]),
         .thr_hi_we_i   (wr_stb && (address == ch_addr(k, OFF_THR_HI))),
         .thr_lo_we_i   (wr_stb && (address == ch_addr(k, OFF_THR_LO))),
         .hold_we_i     (wr_stb && (address == ch_addr(k, OFF_HOLD))),
         .wr_data_i     (wr_data),
         .level_o       (level_ch[k]),
         .thr_hi_o      (thr_hi_ch[k]),
         .thr_lo_o      (thr_lo_ch[k]),
         .hold_o        (hold_ch[k]),
         .open_evt_o    (open_evt_set[k]),
         .state_o       (state_ch[k])
      );
      assign gate_open[k] = (state_ch[k] != CLOSED);
   end

   // A hardware set in the same cycle as a W1C of that bit wins.
   assign clr_new    = (wr_stb && address == ADDR_FLAGS) ? wr_data[N_CH-1:0]   : '0;
   assign clr_open   = (wr_stb && address == ADDR_FLAGS) ? wr_data[8 +: N_CH]  : '0;
   assign new_lvl_d  = (new_lvl_q  & ~clr_new)  | level_ready_in;
   assign open_evt_d = (open_evt_q & ~clr_open) | open_evt_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         new_lvl_q     <= '0;
         open_evt_q    <= '0;
         irq_en_new_q  <= '0;
         irq_en_open_q <= '0;
         enable_q      <= 1'b1;
      end else begin
         new_lvl_q  <= new_lvl_d;
         open_evt_q <= open_evt_d;
         if (wr_stb && address == ADDR_IRQ_EN) begin
            irq_en_new_q  <= wr_data[N_CH-1:0];
            irq_en_open_q <= wr_data[8 +: N_CH];
         end
         if (wr_stb && address == ADDR_CTRL) enable_q <= wr_data[0];
      end
   end

   assign irq = |(new_lvl_q & irq_en_new_q) | |(open_evt_q & irq_en_open_q);

   always_comb begin
      rd_data = '0;
      if (rd_stb) begin
         case (address)
            ADDR_STATUS: rd_data = {8'h00, 8'(gate_open)};
            ADDR_FLAGS:  rd_data = {8'(open_evt_q), 8'(new_lvl_q)};
            ADDR_IRQ_EN: rd_data = {8'(irq_en_open_q), 8'(irq_en_new_q)};
            ADDR_CTRL:   rd_data = {15'd0, enable_q};
            default: begin
               for (int k = 0; k < N_CH; k++) begin
                  if (address == ch_addr(k, OFF_LEVEL))  rd_data = 16'(level_ch[k]);
                  if (address == ch_addr(k, OFF_THR_HI)) rd_data = 16'(thr_hi_ch[k]);
                  if (address == ch_addr(k, OFF_THR_LO)) rd_data = 16'(thr_lo_ch[k]);
                  if (address == ch_addr(k, OFF_HOLD))   rd_data = 16'(hold_ch[k]);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mic_gate_multi_mmio.sv
// Directed bench for mic_gate_multi_mmio built with two channels so the
// unused channel-register windows and flag bits can be exercised.
module tb_mic_gate_multi_mmio;

   localparam int N_CH  = 2;
   localparam int LVL_W = 16;

   logic                  clk;
   logic                  rst;
   logic                  cs;
   logic                  wr_en;
   logic                  rd_en;
   logic [5:0]            address;
   logic [15:0]           wr_data;
   logic [15:0]           rd_data;
   logic [N_CH*LVL_W-1:0] level_in;
   logic [N_CH-1:0]       level_ready_in;
   logic [N_CH-1:0]       gate_open;
   logic                  irq;

   int n_checks = 0;
   int n_fail   = 0;

   mic_gate_multi_mmio #(
      .N_CH (N_CH),
      .LVL_W(LVL_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cs            (cs),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .address       (address),
      .wr_data       (wr_data),
      .rd_data       (rd_data),
      .level_in      (level_in),
      .level_ready_in(level_ready_in),
      .gate_open     (gate_open),
      .irq           (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
      @(negedge clk);
      cs = 1'b1; wr_en = 1'b1; address = a; wr_data = d;
      @(negedge clk);
      cs = 1'b0; wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [15:0] d);
      @(negedge clk);
      cs = 1'b1; rd_en = 1'b1; address = a;
      #1 d = rd_data;
      cs = 1'b0; rd_en = 1'b0;
   endtask

   task automatic send_level(input int ch, input logic [15:0] lvl);
      @(negedge clk);
      level_in[ch*LVL_W +: LVL_W] = lvl;
      level_ready_in = '0;
      level_ready_in[ch] = 1'b1;
      @(negedge clk);
      level_ready_in = '0;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      logic [15:0] exp_v [6];
      logic [5:0]  adr_v [6];
      adr_v = '{6'd9, 6'd10, 6'd11, 6'd3, 6'd0, 6'd1};
      exp_v = '{16'd1200, 16'd1000, 16'd4, 16'd1, 16'd0, 16'd0};
      for (int i = 0; i < 6; i++) begin
         bus_read(adr_v[i], d);
         n_checks++;
         if (d !== exp_v[i]) begin
            n_fail++;
            $display("FAIL reset_read addr=%0d got=%0d exp=%0d", adr_v[i], d, exp_v[i]);
         end
      end
      n_checks++;
      if (gate_open !== 2'b00 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs gate_open=%b irq=%b exp 00/0", gate_open, irq);
      end
      @(negedge clk);
      cs = 1'b1; address = 6'd9;
      #1;
      n_checks++;
      if (rd_data !== 16'd0) begin
         n_fail++;
         $display("FAIL read_without_rd_en got=%h exp=0000", rd_data);
      end
      cs = 1'b0;
   endtask

   task automatic test_hold_gate();
      logic [15:0] d;
      send_level(0, 16'd1300);
      n_checks++;
      if (gate_open[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL ch0_open got=%b exp=1", gate_open[0]);
      end
      for (int i = 1; i <= 5; i++) begin
         send_level(0, 16'd900);
         n_checks++;
         if (gate_open[0] !== (i < 5)) begin
            n_fail++;
            $display("FAIL ch0_hold window=%0d got=%b exp=%b", i, gate_open[0], (i < 5));
         end
      end
      bus_read(6'd1, d);
      n_checks++;
      if (d !== 16'h0101) begin
         n_fail++;
         $display("FAIL ch0_flags got=%h exp=0101", d);
      end
      bus_read(6'd8, d);
      n_checks++;
      if (d !== 16'd900) begin
         n_fail++;
         $display("FAIL ch0_level got=%0d exp=900", d);
      end
      bus_write(6'd1, 16'hFFFF);
      bus_read(6'd1, d);
      n_checks++;
      if (d !== 16'h0000) begin
         n_fail++;
         $display("FAIL flags_w1c got=%h exp=0000", d);
      end
   endtask

   task automatic test_hysteresis();
      logic [15:0] d;
      logic [15:0] lvl_v [10];
      logic        exp_g [10];
      bus_write(6'd15, 16'd2);
      lvl_v = '{16'd1100, 16'd1200, 16'd1000, 16'd1100, 16'd999,
                16'd1300, 16'd900, 16'd900, 16'd900, 16'd0};
      exp_g = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (i == 5) bus_write(6'd1, 16'hFFFF);
         send_level(1, lvl_v[i]);
         n_checks++;
         if (gate_open[1] !== exp_g[i]) begin
            n_fail++;
            $display("FAIL ch1_seq step=%0d lvl=%0d got=%b exp=%b", i, lvl_v[i], gate_open[1], exp_g[i]);
         end
         if (i == 5) begin
            bus_read(6'd1, d);
            n_checks++;
            if (d !== 16'h0002) begin
               n_fail++;
               $display("FAIL hold_reopen_no_evt got=%h exp=0002", d);
            end
         end
      end
      bus_write(6'd15, 16'd0);
      send_level(1, 16'd1300);
      send_level(1, 16'd900);
      n_checks++;
      if (gate_open[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL ch1_hold_zero got=%b exp=0", gate_open[1]);
      end
   endtask

   task automatic test_irq();
      logic [15:0] d;
      bus_write(6'd1, 16'hFFFF);
      bus_write(6'd2, 16'h0100);
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_idle got=%b exp=0", irq);
      end
      send_level(0, 16'd1300);
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_on_open got=%b exp=1", irq);
      end
      bus_write(6'd1, 16'h0100);
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_after_w1c got=%b exp=0", irq);
      end
      bus_write(6'd11, 16'd0);
      send_level(0, 16'd900);
      @(negedge clk);
      cs = 1'b1; wr_en = 1'b1; address = 6'd1; wr_data = 16'h0100;
      level_in[0 +: LVL_W] = 16'd1300;
      level_ready_in = 2'b01;
      @(negedge clk);
      cs = 1'b0; wr_en = 1'b0; level_ready_in = '0;
      bus_read(6'd1, d);
      n_checks++;
      if (d !== 16'h0101 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL set_beats_w1c flags=%h irq=%b exp 0101/1", d, irq);
      end
   endtask

   task automatic test_enable();
      logic [15:0] d;
      bus_write(6'd3, 16'd0);
      @(negedge clk);
      n_checks++;
      if (gate_open[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL disable_closes got=%b exp=0", gate_open[0]);
      end
      bus_write(6'd1, 16'hFFFF);
      send_level(0, 16'd2000);
      n_checks++;
      if (gate_open[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL disabled_stays_closed got=%b exp=0", gate_open[0]);
      end
      bus_read(6'd8, d);
      n_checks++;
      if (d !== 16'd2000) begin
         n_fail++;
         $display("FAIL disabled_level got=%0d exp=2000", d);
      end
      bus_read(6'd1, d);
      n_checks++;
      if (d !== 16'h0001) begin
         n_fail++;
         $display("FAIL disabled_flags got=%h exp=0001", d);
      end
      bus_read(6'd3, d);
      n_checks++;
      if (d !== 16'd0) begin
         n_fail++;
         $display("FAIL ctrl_read got=%h exp=0000", d);
      end
      bus_write(6'd3, 16'd1);
      send_level(0, 16'd2000);
      bus_read(6'd1, d);
      n_checks++;
      if (gate_open[0] !== 1'b1 || d !== 16'h0101) begin
         n_fail++;
         $display("FAIL reenable gate=%b flags=%h exp 1/0101", gate_open[0], d);
      end
   endtask

   task automatic test_map();
      logic [15:0] d;
      bus_write(6'd17, 16'hFFFF);
      bus_write(6'd5, 16'hFFFF);
      for (int a = 4; a < 24; a++) begin
         if (a >= 8 && a < 16) continue;
         bus_read(6'(a), d);
         n_checks++;
         if (d !== 16'd0) begin
            n_fail++;
            $display("FAIL unmapped_read addr=%0d got=%h exp=0000", a, d);
         end
      end
      bus_read(6'd40, d);
      n_checks++;
      if (d !== 16'd0) begin
         n_fail++;
         $display("FAIL addr40_read got=%h exp=0000", d);
      end
      bus_write(6'd2, 16'hFFFF);
      bus_read(6'd2, d);
      n_checks++;
      if (d !== 16'h0303) begin
         n_fail++;
         $display("FAIL irq_en_mask got=%h exp=0303", d);
      end
      send_level(1, 16'd500);
      bus_read(6'd1, d);
      n_checks++;
      if (d !== 16'h0103) begin
         n_fail++;
         $display("FAIL flags_upper_zero got=%h exp=0103", d);
      end
      bus_write(6'd11, 16'h1234);
      bus_read(6'd11, d);
      n_checks++;
      if (d !== 16'h0034) begin
         n_fail++;
         $display("FAIL hold_truncate got=%h exp=0034", d);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (gate_open !== 2'b00 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset gate=%b irq=%b exp 00/0", gate_open, irq);
      end
      @(negedge clk);
      rst = 1'b0;
      bus_read(6'd11, d);
      n_checks++;
      if (d !== 16'd4) begin
         n_fail++;
         $display("FAIL reset_hold got=%0d exp=4", d);
      end
      bus_read(6'd2, d);
      n_checks++;
      if (d !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_irq_en got=%h exp=0000", d);
      end
   endtask

   initial begin
      rst = 1'b1;
      cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      address = '0; wr_data = '0;
      level_in = '0; level_ready_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_hold_gate();
      test_hysteresis();
      test_irq();
      test_enable();
      test_map();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
